// File: rtl/ctrl_word_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ctrl_word_pipe
// Description : Carries the decoder's EX/M/WB control words through the
//               ID/EX, EX/MEM and MEM/WB stage registers. Detects load-use
//               hazards and requests a one-cycle stall with a bubble. Applies
//               branch/jump flushes and freezes the whole pipe once a Break
//               word reaches WB.
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous active-high reset
//               EX/M/WB    - ID-stage control words from the decoder
//               IFID_IR    - ID-stage instruction (rs=[25:21], rt=[20:16])
//               flush      - taken branch/jump resolved in MEM
//               IDEX_*     - control words and rt held in the EX stage
//               EXMEM_*    - control words held in the MEM stage
//               MEMWB_WB   - WB word held in the WB stage
//               load_stall - combinational hold request for PC and IF/ID
//               halted     - sticky, set once Break has reached WB
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_word_pipe #(
    parameter int unsigned EXW   = 16,
    parameter int unsigned MW    = 16,
    parameter int unsigned WBW   = 4,
    parameter int unsigned LU_EN = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [EXW-1:0] EX,
    input  logic [MW-1:0]  M,
    input  logic [WBW-1:0] WB,
    input  logic [31:0]    IFID_IR,
    input  logic           flush,
    output logic [EXW-1:0] IDEX_EX,
    output logic [MW-1:0]  IDEX_M,
    output logic [WBW-1:0] IDEX_WB,
    output logic [4:0]     IDEX_rt,
    output logic [MW-1:0]  EXMEM_M,
    output logic [WBW-1:0] EXMEM_WB,
    output logic [WBW-1:0] MEMWB_WB,
    output logic           load_stall,
    output logic           halted
);

    // WB word layout: {Break, WB_Data[1:0], D_En}
    localparam int unsigned c_BREAK_BIT = WBW - 1;

    logic [EXW-1:0] r_idex_ex;
    logic [MW-1:0]  r_idex_m;
    logic [WBW-1:0] r_idex_wb;
    logic [4:0]     r_idex_rt;
    logic [MW-1:0]  r_exmem_m;
    logic [WBW-1:0] r_exmem_wb;
    logic [WBW-1:0] r_memwb_wb;
    logic           r_halted;

    logic           w_raw_lu;
    logic           w_load_stall;
    logic [4:0]     w_id_rs;
    logic [4:0]     w_id_rt;
    logic           w_unused_ir;

    assign w_id_rs     = IFID_IR[25:21];
    assign w_id_rt     = IFID_IR[20:16];
    // Opcode and immediate/function bits play no part in hazard detection.
    assign w_unused_ir = ^{IFID_IR[31:26], IFID_IR[15:0]};

    // A producer in EX only hazards when it writes a register from a source
    // other than the ALU (WB_Data != 0) and the target is not $0.
    generate
        if (LU_EN != 0) begin : g_lu_on
            assign w_raw_lu = r_idex_wb[0]
                            & (r_idex_wb[2:1] != 2'b00)
                            & (r_idex_rt != 5'd0)
                            & ((r_idex_rt == w_id_rs) | (r_idex_rt == w_id_rt));
        end else begin : g_lu_off
            assign w_raw_lu = 1'b0;
        end
    endgenerate

    // Flush and halt both outrank the stall, so a flushed hazard never
    // inserts a second bubble and a frozen pipe never requests a hold.
    assign w_load_stall = w_raw_lu & ~flush & ~r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idex_ex  <= '0;
            r_idex_m   <= '0;
            r_idex_wb  <= '0;
            r_idex_rt  <= '0;
            r_exmem_m  <= '0;
            r_exmem_wb <= '0;
            r_memwb_wb <= '0;
            r_halted   <= 1'b0;
        end else if (!r_halted) begin
            // Break in WB freezes everything from the next edge on; the
            // stages still advance on the edge that sets halted.
            r_halted   <= r_memwb_wb[c_BREAK_BIT];
            // The instruction in MEM always retires, even on a flush.
            r_memwb_wb <= r_exmem_wb;
            if (flush) begin
                r_idex_ex  <= '0;
                r_idex_m   <= '0;
                r_idex_wb  <= '0;
                r_idex_rt  <= '0;
                r_exmem_m  <= '0;
                r_exmem_wb <= '0;
            end else begin
                r_exmem_m  <= r_idex_m;
                r_exmem_wb <= r_idex_wb;
                if (w_load_stall) begin
                    // Bubble carries rt=0, which clears the stall next cycle.
                    r_idex_ex <= '0;
                    r_idex_m  <= '0;
                    r_idex_wb <= '0;
                    r_idex_rt <= '0;
                end else begin
                    r_idex_ex <= EX;
                    r_idex_m  <= M;
                    r_idex_wb <= WB;
                    r_idex_rt <= w_id_rt;
                end
            end
        end
    end

    assign IDEX_EX    = r_idex_ex;
    assign IDEX_M     = r_idex_m;
    assign IDEX_WB    = r_idex_wb;
    assign IDEX_rt    = r_idex_rt;
    assign EXMEM_M    = r_exmem_m;
    assign EXMEM_WB   = r_exmem_wb;
    assign MEMWB_WB   = r_memwb_wb;
    assign load_stall = w_load_stall;
    assign halted     = r_halted;

endmodule
`default_nettype wire
